// File: rtl/multi_range_divider_if.sv
// Control and output bundle of the multi-channel range divider.
// The master drives enables, sync and the load port; the slave (divider)
// returns the per-channel divided outputs and the load-error flag.
interface multi_range_divider_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              ld;
  logic [CH_W-1:0]   ld_ch;
  logic [WIDTH-1:0]  ld_range;
  logic              ld_mode;
  logic [NUM_CH-1:0] clk_dst;
  logic              ld_err;

  modport master (
    output en, sync, ld, ld_ch, ld_range, ld_mode,
    input  clk_dst, ld_err
  );

  modport slave (
    input  en, sync, ld, ld_ch, ld_range, ld_mode,
    output clk_dst, ld_err
  );
endinterface

// File: rtl/multi_range_divider.sv
// Multi-channel runtime-loadable tick divider.
// Each channel counts clk_src cycles up to its own range and emits either a
// one-cycle tick (pulse mode) or a 50% square wave (square mode). A global
// sync restarts every channel in phase; a load retargets one channel.
module multi_range_divider #(
  parameter int          NUM_CH        = 4,
  parameter int          WIDTH         = 32,
  parameter int          CH_W          = 2,
  parameter int unsigned DEFAULT_RANGE = 100000000,
  parameter bit          DEFAULT_MODE  = 1'b0
) (
  input  logic                clk_src,
  input  logic                rst,
  multi_range_divider_if.slave bus
);

  logic [WIDTH-1:0]  r_count [NUM_CH];
  logic [WIDTH-1:0]  r_range [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_clk_dst;
  logic              r_ld_err;

  logic              w_ld_valid;
  logic [NUM_CH-1:0] w_ld_hit;
  logic [WIDTH-1:0]  w_next [NUM_CH];
  logic [NUM_CH-1:0] w_term;

  // Decode which channel, if any, the load strobe addresses
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_ld_hit   = '0;
    w_ld_valid = bus.ld && (int'(bus.ld_ch) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ld_valid && (int'(bus.ld_ch) == i)) begin
        w_ld_hit[i] = 1'b1;
      end
    end
  end

  // Per-channel increment and terminal-event detection
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_next[i] = r_count[i] + WIDTH'(1);
      w_term[i] = (w_next[i] == r_range[i]);
    end
  end

  // Channel state update: rst > sync > load > normal counting
  always_ff @(posedge clk_src) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the per-channel arrays are flops, not RAM, so each element is reset explicitly.
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i] <= '0;
        r_range[i] <= WIDTH'(DEFAULT_RANGE);
      end
      r_mode    <= {NUM_CH{DEFAULT_MODE}};
      r_clk_dst <= '0;
      r_ld_err  <= 1'b0;
    end else begin
      // An out-of-range target only raises the error flag; nothing else moves.
      r_ld_err <= bus.ld && !w_ld_valid;

      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ld_hit[i]) begin
          r_range[i] <= bus.ld_range;
          r_mode[i]  <= bus.ld_mode;
        end

        if (bus.sync || w_ld_hit[i]) begin
          // Restart in phase: first tick lands exactly range cycles later.
          r_count[i]   <= '0;
          r_clk_dst[i] <= 1'b0;
        end else if (bus.en[i] && (r_range[i] != '0)) begin
          r_count[i]   <= w_term[i] ? '0 : w_next[i];
          r_clk_dst[i] <= r_mode[i] ? (r_clk_dst[i] ^ w_term[i]) : w_term[i];
        end else begin
          // Disabled or idle: count holds, pulse drops, square keeps its level.
          if (!r_mode[i]) begin
            r_clk_dst[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.clk_dst = r_clk_dst;
  assign bus.ld_err  = r_ld_err;

endmodule

// File: tb/tb_multi_range_divider.sv
// Self-checking bench for multi_range_divider. A 4-channel instance is
// checked against a phase/tick-count reference model plus directed timing
// constants; a 3-channel instance exercises the invalid load target.
module tb_multi_range_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multi_range_divider_if #(.NUM_CH(4), .WIDTH(32), .CH_W(2)) bus ();
  multi_range_divider_if #(.NUM_CH(3), .WIDTH(32), .CH_W(2)) bus3 ();

  multi_range_divider #(
    .NUM_CH(4), .WIDTH(32), .CH_W(2), .DEFAULT_RANGE(5), .DEFAULT_MODE(1'b0)
  ) dut (
    .clk_src(clk),
    .rst    (rst),
    .bus    (bus)
  );

  multi_range_divider #(
    .NUM_CH(3), .WIDTH(32), .CH_W(2), .DEFAULT_RANGE(5), .DEFAULT_MODE(1'b0)
  ) dut3 (
    .clk_src(clk),
    .rst    (rst),
    .bus    (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model for the 4-channel instance. Each channel is described by
  // how many enabled cycles have elapsed since its last restart (phase) and
  // how many terminal events it has seen (ticks): a tick happens whenever the
  // phase becomes a multiple of range; square level is the tick-count parity.
  longint unsigned m_phase [4];
  longint unsigned m_ticks [4];
  logic [31:0]     m_range [4];
  bit              m_mode  [4];
  bit              m_pulse [4];
  bit              m_err;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_phase[c] <= 0;
        m_ticks[c] <= 0;
        m_range[c] <= 32'd5;
        m_mode[c]  <= 1'b0;
        m_pulse[c] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (bus.ld && (int'(bus.ld_ch) == c)) begin
          m_range[c] <= bus.ld_range;
          m_mode[c]  <= bus.ld_mode;
        end
        if (bus.sync || (bus.ld && (int'(bus.ld_ch) == c))) begin
          m_phase[c] <= 0;
          m_ticks[c] <= 0;
          m_pulse[c] <= 1'b0;
        end else if (bus.en[c] && (m_range[c] != 0)) begin
          m_phase[c] <= m_phase[c] + 1;
          m_pulse[c] <= (((m_phase[c] + 1) % 64'(m_range[c])) == 0);
          if (((m_phase[c] + 1) % 64'(m_range[c])) == 0) begin
            m_ticks[c] <= m_ticks[c] + 1;
          end
        end else begin
          m_pulse[c] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] model_out();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) begin
      r[c] = m_mode[c] ? m_ticks[c][0] : m_pulse[c];
    end
    return r;
  endfunction

  // Cycles since reset release; the 3-channel instance only ever sees
  // default settings, so its outputs follow this directly.
  int unsigned since_rst;
  always @(posedge clk) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  function automatic logic [2:0] exp3();
    return ((since_rst != 0) && (since_rst % 5 == 0)) ? 3'b111 : 3'b000;
  endfunction

  // One clock: inputs applied before the rising edge, outputs observed at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.en       = 4'hF;
    bus.sync     = 1'b0;
    bus.ld       = 1'b0;
    bus.ld_ch    = 2'd0;
    bus.ld_range = 32'd0;
    bus.ld_mode  = 1'b0;
    bus3.en       = 3'b111;
    bus3.sync     = 1'b0;
    bus3.ld       = 1'b0;
    bus3.ld_ch    = 2'd0;
    bus3.ld_range = 32'd0;
    bus3.ld_mode  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    idle_inputs();
    rst          = 1'b1;
    bus.ld       = 1'b1;   // must be discarded under reset
    bus.ld_ch    = 2'd1;
    bus.ld_range = 32'd3;
    bus.ld_mode  = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (bus.clk_dst !== 4'h0 || bus.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: clk_dst=%b ld_err=%b required 0000/0", bus.clk_dst, bus.ld_err);
    end
    n_checks++;
    if (bus3.clk_dst !== 3'b000 || bus3.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state3: clk_dst=%b ld_err=%b required 000/0", bus3.clk_dst, bus3.ld_err);
    end
    bus.ld = 1'b0;
    rst    = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = (k % 5 == 0) ? 4'hF : 4'h0;
      n_checks++;
      if (bus.clk_dst !== exp || bus.ld_err !== 1'b0) begin
        n_fail++;
        $display("FAIL default_period cycle %0d: clk_dst=%b ld_err=%b required %b/0",
                 k, bus.clk_dst, bus.ld_err, exp);
      end
      n_checks++;
      if (bus.clk_dst !== model_out()) begin
        n_fail++;
        $display("FAIL default_model cycle %0d: clk_dst=%b model %b", k, bus.clk_dst, model_out());
      end
    end
  endtask

  task automatic test_invalid_target();
    bus3.ld       = 1'b1;
    bus3.ld_ch    = 2'd3;
    bus3.ld_range = 32'd2;
    bus3.ld_mode  = 1'b1;
    step();
    bus3.ld = 1'b0;
    n_checks++;
    if (bus3.ld_err !== 1'b1 || bus3.clk_dst !== exp3()) begin
      n_fail++;
      $display("FAIL invalid_ld_flag: ld_err=%b clk_dst=%b required 1/%b",
               bus3.ld_err, bus3.clk_dst, exp3());
    end
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if (bus3.ld_err !== 1'b0 || bus3.clk_dst !== exp3()) begin
        n_fail++;
        $display("FAIL invalid_ld_after cycle %0d: ld_err=%b clk_dst=%b required 0/%b",
                 k, bus3.ld_err, bus3.clk_dst, exp3());
      end
    end
  endtask

  task automatic test_load_mode();
    logic exp1;
    for (int j = 0; j < 18; j++) begin
      bus.ld       = (j == 0);
      bus.ld_ch    = 2'd1;
      bus.ld_range = 32'd3;
      bus.ld_mode  = 1'b1;
      step();
      exp1 = ((j / 3) % 2) == 1;
      n_checks++;
      if (bus.clk_dst[1] !== exp1) begin
        n_fail++;
        $display("FAIL load_square cycle %0d: clk_dst[1]=%b required %b", j, bus.clk_dst[1], exp1);
      end
      n_checks++;
      if (bus.clk_dst !== model_out() || bus.ld_err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_model cycle %0d: clk_dst=%b ld_err=%b model %b/0",
                 j, bus.clk_dst, bus.ld_err, model_out());
      end
    end
    bus.ld = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic exp0;
    for (int j = 0; j < 16; j++) begin
      bus.ld       = (j == 0);
      bus.ld_ch    = 2'd0;
      bus.ld_range = 32'd4;
      bus.ld_mode  = 1'b0;
      bus.en[0]    = !(j >= 3 && j <= 9);
      step();
      exp0 = (j == 11) || (j == 15);
      n_checks++;
      if (bus.clk_dst[0] !== exp0) begin
        n_fail++;
        $display("FAIL enable_gap cycle %0d: clk_dst[0]=%b required %b", j, bus.clk_dst[0], exp0);
      end
      n_checks++;
      if (bus.clk_dst !== model_out()) begin
        n_fail++;
        $display("FAIL enable_model cycle %0d: clk_dst=%b model %b", j, bus.clk_dst, model_out());
      end
    end
    bus.ld = 1'b0;
    bus.en = 4'hF;
  endtask

  task automatic test_sync_ld();
    logic [3:0] exp;
    step();
    step();
    for (int j = 0; j < 9; j++) begin
      bus.sync     = (j == 0);
      bus.ld       = (j == 0);
      bus.ld_ch    = 2'd2;
      bus.ld_range = 32'd2;
      bus.ld_mode  = 1'b0;
      step();
      exp[0] = (j > 0) && (j % 4 == 0);
      exp[1] = ((j / 3) % 2) == 1;
      exp[2] = (j > 0) && (j % 2 == 0);
      exp[3] = (j > 0) && (j % 5 == 0);
      n_checks++;
      if (bus.clk_dst !== exp) begin
        n_fail++;
        $display("FAIL sync_ld cycle %0d: clk_dst=%b required %b", j, bus.clk_dst, exp);
      end
      n_checks++;
      if (bus.clk_dst !== model_out()) begin
        n_fail++;
        $display("FAIL sync_model cycle %0d: clk_dst=%b model %b", j, bus.clk_dst, model_out());
      end
    end
    bus.sync = 1'b0;
    bus.ld   = 1'b0;
  endtask

  task automatic test_edge_ranges();
    logic [3:0] exp;
    bus.ld       = 1'b1;
    bus.ld_ch    = 2'd0;
    bus.ld_range = 32'd0;
    bus.ld_mode  = 1'b0;
    step();
    bus.ld_ch    = 2'd3;
    bus.ld_range = 32'd1;
    step();
    bus.ld = 1'b0;
    n_checks++;
    if (bus.clk_dst[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL range1_load: clk_dst[3]=%b required 0", bus.clk_dst[3]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (bus.clk_dst[0] !== 1'b0 || bus.clk_dst[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL range0_range1 cycle %0d: clk_dst[0]=%b clk_dst[3]=%b required 0/1",
                 k, bus.clk_dst[0], bus.clk_dst[3]);
      end
      n_checks++;
      if (bus.clk_dst !== model_out()) begin
        n_fail++;
        $display("FAIL edge_model cycle %0d: clk_dst=%b model %b", k, bus.clk_dst, model_out());
      end
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.clk_dst !== 4'h0 || bus.ld_err !== 1'b0 || bus3.clk_dst !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_reset: clk_dst=%b ld_err=%b clk_dst3=%b required 0000/0/000",
               bus.clk_dst, bus.ld_err, bus3.clk_dst);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k % 5 == 0) ? 4'hF : 4'h0;
      n_checks++;
      if (bus.clk_dst !== exp) begin
        n_fail++;
        $display("FAIL restart_period cycle %0d: clk_dst=%b required %b", k, bus.clk_dst, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 99) == 0);
      bus.en       = 4'($urandom_range(0, 15));
      bus.sync     = ($urandom_range(0, 19) == 0);
      bus.ld       = ($urandom_range(0, 3) == 0);
      bus.ld_ch    = 2'($urandom_range(0, 3));
      bus.ld_range = 32'($urandom_range(0, 6));
      bus.ld_mode  = ($urandom_range(0, 1) == 1);
      step();
      n_checks++;
      if (bus.clk_dst !== model_out() || bus.ld_err !== m_err) begin
        n_fail++;
        $display("FAIL random cycle %0d: clk_dst=%b ld_err=%b model %b/%b",
                 k, bus.clk_dst, bus.ld_err, model_out(), m_err);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_invalid_target();
    test_load_mode();
    test_enable_gating();
    test_sync_ld();
    test_edge_ranges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
